hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Sequences the five-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Produces PC and IF/ID load enables, the IF/ID flush (resetIF), the ID/EX bubble (Inconditional_Reset), and the ID-stage operand-forward selects that drive the PA/PB muxes.
- An FSM handles load-use stalls, taken-branch/jump flushes, and serializing instructions that must drain the back end before issuing.

Parameters:
- DRAIN_CYCLES, 3: bubbles inserted ahead of a serializing instruction. Legal range 1–7.
- REG_W, 5: register-index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction reads rs1/rs2.
- id_serialize  in  1  the ID instruction is FENCE/ECALL-class.
- ex_rd, mem_rd, wb_rd  in  REG_W  destination registers in EX, MEM and WB.
- ex_rf_enable, mem_rf_enable, wb_rf_enable  in  1  register-file write pending in that stage.
- ex_load  in  1  the EX instruction is a load.
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX.
- pc_le  out  1  PC load enable.
- ifid_le  out  1  IF/ID load enable.
- ifid_flush  out  1  drives IF/ID resetIF.
- idex_bubble  out  1  drives ID/EX Inconditional_Reset.
- fwd_a, fwd_b  out  2  operand source: 00 register file, 01 EX ALU, 10 MEM data mux, 11 WB.
- stall_count, flush_count  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset: one clock; Reset is synchronous and active-low.
  - While Reset=0 at a clock edge: state←RUN, drain_cnt←0, counters←0.
  - While Reset=0, outputs are forced combinationally: pc_le=0, ifid_le=0, ifid_flush=1, idex_bubble=1, fwd_a=fwd_b=00.
  - Reset asserted mid-DRAIN or mid-LDSTALL aborts to RUN on that edge.
- States:
  - RUN: normal flow.
  - LDSTALL: the single cycle after a load-use stall.
  - DRAIN: counting down bubbles ahead of a serializing instruction.
- Load-use hazard (ld_haz) = ex_load & ex_rf_enable & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority per cycle: ex_redirect > ld_haz > id_serialize.
- ex_redirect, in any state:
  - Outputs: pc_le=1, ifid_le=0, ifid_flush=1, idex_bubble=1.
  - Next state RUN; drain_cnt←0.
  - Flush overrides LE: IF/ID must zero, not load.
- RUN with ld_haz:
  - Outputs: pc_le=0, ifid_le=0, idex_bubble=1, ifid_flush=0.
  - Next state LDSTALL. Exactly one bubble per load-use pair.
- LDSTALL:
  - Outputs normal (pc_le=ifid_le=1, bubble=0). ld_haz is not re-evaluated.
  - Next state RUN.
- RUN with id_serialize:
  - Outputs: pc_le=0, ifid_le=0, idex_bubble=1.
  - drain_cnt←DRAIN_CYCLES-1; next state DRAIN.
- DRAIN:
  - drain_cnt≠0: hold (pc_le=0, ifid_le=0, idex_bubble=1); drain_cnt decrements.
  - drain_cnt==0: release (pc_le=1, ifid_le=1, idex_bubble=0); next state RUN.
  - Total: exactly DRAIN_CYCLES bubbles, then the instruction issues.
  - Back-to-back serializing instructions each drain independently.
- RUN, no event: pc_le=1, ifid_le=1, ifid_flush=0, idex_bubble=0.
- Forwarding, computed combinationally and independently per operand (rs1→fwd_a, rs2→fwd_b):
  - Source rs==0 → 00.
  - Otherwise first match wins: EX (ex_rf_enable & !ex_load & rd==rs) → 01; MEM → 10; WB → 11; else 00.
- No outputs are registered. Only the state, drain_cnt and counters are flops.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments by 1 on every cycle with Reset=1 and pc_le=0.
  - flush_count increments by 1 on every cycle with Reset=1 and ifid_flush=1.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: ports remain present, tied to 32'h0, and no counter flops are synthesized.

Decomposition:
- Package hazard_pkg:
  - State encoding: RUN=2'd0, LDSTALL=2'd1, DRAIN=2'd2.
  - Forward-select constants FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
- Sub-module hazard_fwd_sel: pure combinational priority match, instantiated twice (operand A, operand B).

Test Plan:
1. Reset held low 3 cycles, then released → during reset pc_le=0, ifid_flush=1, idex_bubble=1; first cycle after release pc_le=1, ifid_le=1, fwd=00.
2. lw x5 in EX (ex_load=1, ex_rd=5), ID add with id_rs1=5 → one cycle pc_le=0, idex_bubble=1; next cycle in LDSTALL with ex_rd=5 in MEM → pc_le=1 and fwd_a=10.
3. ex_redirect=1 in the same cycle as ld_haz=1 → ifid_flush=1, idex_bubble=1, pc_le=1; state RUN; no LDSTALL entered.
4. id_serialize=1 with DRAIN_CYCLES=3 → bubbles on cycles 0, 1, 2; release on cycle 3; stall_count=3 with HAZARD_PERF_CNT_EN defined.
5. id_rs2=7 with ex_rd=7 (non-load), mem_rd=7 and wb_rd=7, all rf_enable=1 → fwd_b=01; with id_rs2=0 → fwd_b=00.
6. Reset pulsed low at DRAIN drain_cnt=1 → next cycle state RUN, drain_cnt=0, counters 0.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard/stall controller: FSM state
// encoding and the operand-forward select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Wide enough for the largest legal drain length (7).
  localparam int DRAIN_W = 3;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX/MEM/WB hazard inputs
// and the enable/flush/forward/counter outputs.
interface hazard_stall_controller_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_serialize;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] mem_rd;
  logic [REG_W-1:0] wb_rd;
  logic             ex_rf_enable;
  logic             mem_rf_enable;
  logic             wb_rf_enable;
  logic             ex_load;
  logic             ex_redirect;
  logic             pc_le;
  logic             ifid_le;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [31:0]      stall_count;
  logic [31:0]      flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_serialize,
           ex_rd, mem_rd, wb_rd, ex_rf_enable, mem_rf_enable, wb_rf_enable,
           ex_load, ex_redirect,
    input  pc_le, ifid_le, ifid_flush, idex_bubble, fwd_a, fwd_b,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_serialize,
           ex_rd, mem_rd, wb_rd, ex_rf_enable, mem_rf_enable, wb_rf_enable,
           ex_load, ex_redirect,
    output pc_le, ifid_le, ifid_flush, idex_bubble, fwd_a, fwd_b,
           stall_count, flush_count
  );

endinterface

// File: rtl/hazard_stall_controller_fwd_sel.sv
// Per-operand forward select: nearest producing stage wins, x0 never forwards.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_en,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_en,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (ex_en && (ex_rd == rs))        sel = FWD_EX;
      else if (mem_en && (mem_rd == rs)) sel = FWD_MEM;
      else if (wb_en && (wb_rd == rs))   sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use stalls, redirect flushes,
// serializing-instruction drains and ID-stage forward selects.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_W        = 5
) (
  input  logic                     clk,
  input  logic                     Reset,
  hazard_stall_controller_if.slave hz
);

  state_t             state;
  state_t             state_n;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] drain_cnt_n;

  logic       ld_haz;
  logic       pc_le;
  logic       ifid_le;
  logic       ifid_flush;
  logic       idex_bubble;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  assign ld_haz = hz.ex_load && hz.ex_rf_enable && (hz.ex_rd != '0) &&
                  ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                   (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // A load in EX has no result yet, so it is never an EX forward source.
  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .rs     (hz.id_rs1),
    .ex_rd  (hz.ex_rd),
    .ex_en  (hz.ex_rf_enable && !hz.ex_load),
    .mem_rd (hz.mem_rd),
    .mem_en (hz.mem_rf_enable),
    .wb_rd  (hz.wb_rd),
    .wb_en  (hz.wb_rf_enable),
    .sel    (fwd_a_raw)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .rs     (hz.id_rs2),
    .ex_rd  (hz.ex_rd),
    .ex_en  (hz.ex_rf_enable && !hz.ex_load),
    .mem_rd (hz.mem_rd),
    .mem_en (hz.mem_rf_enable),
    .wb_rd  (hz.wb_rd),
    .wb_en  (hz.wb_rf_enable),
    .sel    (fwd_b_raw)
  );

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    pc_le       = 1'b1;
    ifid_le     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!Reset) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_n     = RUN;
      drain_cnt_n = '0;
    end else if (hz.ex_redirect) begin
      // Flush beats load: IF/ID must be zeroed, not loaded.
      ifid_le     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_n     = RUN;
      drain_cnt_n = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (ld_haz) begin
            pc_le       = 1'b0;
            ifid_le     = 1'b0;
            idex_bubble = 1'b1;
            state_n     = LDSTALL;
          end else if (hz.id_serialize) begin
            pc_le       = 1'b0;
            ifid_le     = 1'b0;
            idex_bubble = 1'b1;
            drain_cnt_n = DRAIN_W'(DRAIN_CYCLES - 1);
            state_n     = DRAIN;
          end
        end
        LDSTALL: state_n = RUN;
        DRAIN: begin
          if (drain_cnt != '0) begin
            pc_le       = 1'b0;
            ifid_le     = 1'b0;
            idex_bubble = 1'b1;
            drain_cnt_n = drain_cnt - DRAIN_W'(1);
          end else begin
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign hz.pc_le       = pc_le;
  assign hz.ifid_le     = ifid_le;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.fwd_a       = Reset ? fwd_a_raw : FWD_RF;
  assign hz.fwd_b       = Reset ? fwd_b_raw : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_le)     stall_q <= stall_q + 32'd1;
      if (ifid_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;
`else
  assign hz.stall_count = 32'h0;
  assign hz.flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: vector table, directed
// corner sequences and randomized traffic against a cycle-schedule model.
module tb_hazard_stall_controller;

  localparam int DC = 3;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  hazard_stall_controller_if #(.REG_W(5)) hz ();

  hazard_stall_controller #(.DRAIN_CYCLES(DC), .REG_W(5)) dut (
    .clk   (clk),
    .Reset (Reset),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: absolute-cycle schedule of pending stall events.
  int          cyc        = 0;
  int          release_at = -1;
  int          ldfree_at  = -1;
  logic [31:0] m_stall    = '0;
  logic [31:0] m_flush    = '0;
  logic        e_pc, e_ifid, e_fl, e_bub;
  logic [1:0]  e_fa, e_fb;
  int          nx_release, nx_ldfree;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2, ser;
    logic [4:0] exrd, memrd, wbrd;
    logic       exen, memen, wben, exload, redir;
    logic       epc, eifid, efl, ebub;
    logic [1:0] efa, efb;
    string      name;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    logic [4:0] rd[3];
    logic       en[3];
    rd[0] = hz.ex_rd;  en[0] = hz.ex_rf_enable && !hz.ex_load;
    rd[1] = hz.mem_rd; en[1] = hz.mem_rf_enable;
    rd[2] = hz.wb_rd;  en[2] = hz.wb_rf_enable;
    if (rs == 5'd0) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (en[i] && rd[i] == rs) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic logic ld_use();
    return hz.ex_load && hz.ex_rf_enable && hz.ex_rd != 5'd0 &&
           ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
            (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
  endfunction

  task automatic model_eval();
    nx_release = release_at;
    nx_ldfree  = ldfree_at;
    e_fa = Reset ? fwd_ref(hz.id_rs1) : 2'd0;
    e_fb = Reset ? fwd_ref(hz.id_rs2) : 2'd0;
    {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;
    if (!Reset) begin
      {e_pc, e_ifid, e_fl, e_bub} = 4'b0011;
      nx_release = -1; nx_ldfree = -1;
    end else if (hz.ex_redirect) begin
      {e_pc, e_ifid, e_fl, e_bub} = 4'b1011;
      nx_release = -1; nx_ldfree = -1;
    end else if (release_at >= 0) begin
      if (cyc < release_at) {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
      else nx_release = -1;
    end else if (cyc == ldfree_at) begin
      nx_ldfree = -1;
    end else if (ld_use()) begin
      {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
      nx_ldfree = cyc + 1;
    end else if (hz.id_serialize) begin
      {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
      nx_release = cyc + DC;
    end
  endtask

  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, ".pc_le"},       hz.pc_le,       e_pc);
    chk({tag, ".ifid_le"},     hz.ifid_le,     e_ifid);
    chk({tag, ".ifid_flush"},  hz.ifid_flush,  e_fl);
    chk({tag, ".idex_bubble"}, hz.idex_bubble, e_bub);
    chk({tag, ".fwd_a"},       hz.fwd_a,       e_fa);
    chk({tag, ".fwd_b"},       hz.fwd_b,       e_fb);
    chk({tag, ".stall_count"}, hz.stall_count, m_stall);
    chk({tag, ".flush_count"}, hz.flush_count, m_flush);
    @(posedge clk);
    release_at = nx_release;
    ldfree_at  = nx_ldfree;
`ifdef HAZARD_PERF_CNT_EN
    if (!Reset) begin
      m_stall = '0; m_flush = '0;
    end else begin
      if (!e_pc) m_stall = m_stall + 32'd1;
      if (e_fl)  m_flush = m_flush + 32'd1;
    end
`endif
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
    hz.id_serialize = 0; hz.ex_rd = 0; hz.mem_rd = 0; hz.wb_rd = 0;
    hz.ex_rf_enable = 0; hz.mem_rf_enable = 0; hz.wb_rf_enable = 0;
    hz.ex_load = 0; hz.ex_redirect = 0;
  endtask

  task automatic apply_row(input vec_t v);
    hz.id_rs1 = v.rs1; hz.id_rs2 = v.rs2; hz.id_uses_rs1 = v.u1; hz.id_uses_rs2 = v.u2;
    hz.id_serialize = v.ser; hz.ex_rd = v.exrd; hz.mem_rd = v.memrd; hz.wb_rd = v.wbrd;
    hz.ex_rf_enable = v.exen; hz.mem_rf_enable = v.memen; hz.wb_rf_enable = v.wben;
    hz.ex_load = v.exload; hz.ex_redirect = v.redir;
  endtask

  task automatic set_lduse(input logic [4:0] r);
    hz.ex_load = 1; hz.ex_rf_enable = 1; hz.ex_rd = r;
    hz.id_rs1 = r; hz.id_uses_rs1 = 1;
  endtask

  initial begin
    //          rs1 rs2 u1 u2 ser exrd mrd wrd exe me we ld rd  pc if fl bb fa fb
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "idle"};
    tbl[1]  = '{0, 7, 0, 1, 0, 7, 7, 7, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, "fwd_ex"};
    tbl[2]  = '{0, 7, 0, 1, 0, 7, 7, 7, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 2, "fwd_mem"};
    tbl[3]  = '{0, 7, 0, 1, 0, 7, 7, 7, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 3, "fwd_wb"};
    tbl[4]  = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, "x0_no_fwd"};
    tbl[5]  = '{5, 0, 1, 0, 0, 5, 5, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 2, 0, "lduse_rs1"};
    tbl[6]  = '{5, 0, 0, 0, 0, 5, 5, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 2, 0, "load_no_use"};
    tbl[7]  = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, "load_x0"};
    tbl[8]  = '{5, 0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, "redir_over_ld"};
    tbl[9]  = '{3, 3, 1, 1, 1, 3, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, "serialize"};
    tbl[10] = '{0, 3, 0, 1, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, "lduse_rs2"};

    Reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset held three cycles, then first normal cycle.
    repeat (3) step("reset_hold");
    Reset = 1'b1;
    #1;
    chk("post_reset.pc_le", hz.pc_le, 1'b1);
    chk("post_reset.ifid_le", hz.ifid_le, 1'b1);
    chk("post_reset.fwd_a", hz.fwd_a, 2'b00);
    step("post_reset");

    foreach (tbl[i]) begin
      Reset = 1'b0; idle_inputs();
      step("tbl_reset");
      Reset = 1'b1;
      apply_row(tbl[i]);
      #1;
      chk({tbl[i].name, ".pc_le"},       hz.pc_le,       tbl[i].epc);
      chk({tbl[i].name, ".ifid_le"},     hz.ifid_le,     tbl[i].eifid);
      chk({tbl[i].name, ".ifid_flush"},  hz.ifid_flush,  tbl[i].efl);
      chk({tbl[i].name, ".idex_bubble"}, hz.idex_bubble, tbl[i].ebub);
      chk({tbl[i].name, ".fwd_a"},       hz.fwd_a,       tbl[i].efa);
      chk({tbl[i].name, ".fwd_b"},       hz.fwd_b,       tbl[i].efb);
      step(tbl[i].name);
    end

    // Load-use: one bubble, then load result forwarded from MEM.
    idle_inputs(); step("idle");
    set_lduse(5);
    #1;
    chk("lu.stall_pc_le", hz.pc_le, 1'b0);
    chk("lu.stall_bubble", hz.idex_bubble, 1'b1);
    step("lu_stall");
    hz.ex_load = 0; hz.ex_rf_enable = 0; hz.ex_rd = 9;
    hz.mem_rd = 5; hz.mem_rf_enable = 1;
    #1;
    chk("lu.release_pc_le", hz.pc_le, 1'b1);
    chk("lu.release_fwd_a", hz.fwd_a, 2'b10);
    step("lu_release");

    // LDSTALL ignores a hazard still visible on its inputs.
    idle_inputs(); set_lduse(6);
    step("lu2_stall");
    #1;
    chk("lu2.ldstall_no_reeval", hz.pc_le, 1'b1);
    step("lu2_ldstall");
    idle_inputs(); step("idle");

    // Redirect beats load-use and does not enter LDSTALL.
    set_lduse(4); hz.ex_redirect = 1;
    #1;
    chk("redir.flush", hz.ifid_flush, 1'b1);
    chk("redir.bubble", hz.idex_bubble, 1'b1);
    chk("redir.pc_le", hz.pc_le, 1'b1);
    step("redir");
    hz.ex_redirect = 0;
    #1;
    chk("redir.then_run_stall", hz.pc_le, 1'b0);
    step("redir_after");
    idle_inputs(); step("idle");

    // Serialize with counters cleared: DC bubbles then release.
    Reset = 1'b0; step("ser_reset"); Reset = 1'b1;
    hz.id_serialize = 1;
    for (int k = 0; k <= DC; k++) begin
      #1;
      chk($sformatf("ser.bubble_c%0d", k), hz.idex_bubble, (k < DC) ? 1'b1 : 1'b0);
      step("ser");
    end
    hz.id_serialize = 0;
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("ser.stall_count", hz.stall_count, 32'd3);
`else
    chk("ser.stall_count", hz.stall_count, 32'd0);
`endif
    step("ser_done");

    // Back-to-back serializing instructions.
    hz.id_serialize = 1;
    repeat (2 * (DC + 1)) step("ser_b2b");
    hz.id_serialize = 0; step("idle");

    // Reset mid-DRAIN aborts to RUN and clears counters.
    hz.id_serialize = 1;
    step("abort_ser0");
    step("abort_ser1");
    Reset = 1'b0; step("abort_reset");
    Reset = 1'b1; hz.id_serialize = 0;
    #1;
    chk("abort.run_pc_le", hz.pc_le, 1'b1);
    chk("abort.stall_count", hz.stall_count, 32'd0);
    chk("abort.flush_count", hz.flush_count, 32'd0);
    step("abort_run");
    hz.id_serialize = 1;
    repeat (DC + 1) step("abort_full_drain");
    hz.id_serialize = 0; step("idle");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      Reset            = ($urandom_range(0, 39) != 0);
      hz.id_rs1        = 5'($urandom_range(0, 3));
      hz.id_rs2        = 5'($urandom_range(0, 3));
      hz.id_uses_rs1   = 1'($urandom);
      hz.id_uses_rs2   = 1'($urandom);
      hz.id_serialize  = ($urandom_range(0, 7) == 0);
      hz.ex_rd         = 5'($urandom_range(0, 3));
      hz.mem_rd        = 5'($urandom_range(0, 3));
      hz.wb_rd         = 5'($urandom_range(0, 3));
      hz.ex_rf_enable  = 1'($urandom);
      hz.mem_rf_enable = 1'($urandom);
      hz.wb_rf_enable  = 1'($urandom);
      hz.ex_load       = ($urandom_range(0, 2) == 0);
      hz.ex_redirect   = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
